// File: rtl/qformat_pkg.sv
// Shared sign-magnitude Q-format definitions: default widths, divider state
// encoding and the sign/magnitude/saturating-pack helpers.
package qformat_pkg;

    localparam int QF_N = 32;
    localparam int QF_Q = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } qdiv_state_t;

    function automatic logic sm_sign(input logic [QF_N-1:0] x);
        return x[QF_N-1];
    endfunction

    function automatic logic [QF_N-2:0] sm_mag(input logic [QF_N-1:0] x);
        return x[QF_N-2:0];
    endfunction

    // A zero magnitude always packs with a positive sign (no negative zero).
    function automatic logic [QF_N-1:0] sm_pack(input logic sign,
                                                input logic [QF_N-2:0] mag,
                                                input logic sat);
        logic [QF_N-2:0] m;
        m = sat ? '1 : mag;
        return {sign && (m != '0), m};
    endfunction

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division bit: shift the next numerator bit into the remainder,
// then subtract the divisor when it fits.
module qdiv_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_rem,
    input  logic         i_bit,
    input  logic [N-2:0] i_div,
    output logic [N-1:0] o_rem,
    output logic         o_qbit
);

    logic [N:0]   w_shift;
    logic [N-1:0] w_diff;
    logic         w_ge;

    // The true difference is below the divisor, so N bits hold it exactly.
    assign w_shift = {i_rem, i_bit};
    assign w_ge    = (w_shift >= {2'b00, i_div});
    assign w_diff  = w_shift[N-1:0] - {1'b0, i_div};
    assign o_rem   = w_ge ? w_diff : w_shift[N-1:0];
    assign o_qbit  = w_ge;

endmodule

// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider: |a|*2^Q/|b| by restoring
// division, one quotient bit per clock, with saturation and divide-by-zero.
module qdiv_seq
    import qformat_pkg::*;
#(
    parameter int N = QF_N,
    parameter int Q = QF_Q
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic         o_overflow,
    output logic         o_div_by_zero
);

    localparam int NUM_W = N - 1 + Q;
    localparam int CNT_W = $clog2(N + Q);

    // Handshake: i_start is taken on any edge where o_busy is low (IDLE or
    // DONE); o_done pulses one cycle and the result holds until the next take.
    qdiv_state_t      r_state;
    qdiv_state_t      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [N-2:0]     r_mag_a;
    logic [N-2:0]     r_mag_b;
    logic             r_sign;
    logic             r_dbz;
    logic [N-1:0]     r_rem;
    logic [NUM_W-1:0] r_quo;

    logic             w_accept;
    logic             w_last;
    logic             w_b_zero;
    logic [CNT_W-1:0] w_idx;
    logic [NUM_W-1:0] w_num;
    logic             w_num_bit;
    logic [N-1:0]     w_rem_next;
    logic             w_qbit;
    logic [NUM_W-1:0] w_quo_final;
    logic             w_ovf;
    logic [N-1:0]     w_result;

    assign w_accept  = i_start && (r_state != RUN);
    assign w_last    = (r_state == RUN) && (r_cnt == CNT_W'(1));
    assign w_b_zero  = (sm_mag(i_divisor) == '0);
    assign w_idx     = r_cnt - 1'b1;
    assign w_num     = {r_mag_a, {Q{1'b0}}};
    assign w_num_bit = w_num[w_idx];

    qdiv_step #(.N(N)) u_step (
        .i_rem  (r_rem),
        .i_bit  (w_num_bit),
        .i_div  (r_mag_b),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    // Bit 0 of r_quo is still clear on the last iteration; fold in its bit.
    assign w_quo_final = r_quo | NUM_W'(w_qbit);
    assign w_ovf       = |w_quo_final[NUM_W-1:N-1];
    assign w_result    = r_dbz ? sm_pack(r_sign, '1, 1'b0)
                               : sm_pack(r_sign, w_quo_final[N-2:0], w_ovf);

    assign o_busy = (r_state == RUN);
    assign o_done = (r_state == DONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = i_start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A zero divisor spends a single RUN cycle so its o_done lands one cycle
    // after acceptance; the iteration result is discarded in that case.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_mag_a       <= '0;
            r_mag_b       <= '0;
            r_sign        <= 1'b0;
            r_dbz         <= 1'b0;
            r_rem         <= '0;
            r_quo         <= '0;
            o_quotient    <= '0;
            o_overflow    <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mag_a <= sm_mag(i_dividend);
                r_mag_b <= sm_mag(i_divisor);
                r_sign  <= sm_sign(i_dividend) ^ sm_sign(i_divisor);
                r_dbz   <= w_b_zero;
                r_cnt   <= w_b_zero ? CNT_W'(1) : CNT_W'(NUM_W);
                r_rem   <= '0;
                r_quo   <= '0;
            end else if (r_state == RUN) begin
                r_rem        <= w_rem_next;
                r_quo[w_idx] <= w_qbit;
                r_cnt        <= r_cnt - 1'b1;
                if (w_last) begin
                    o_quotient    <= w_result;
                    o_overflow    <= w_ovf && !r_dbz;
                    o_div_by_zero <= r_dbz;
                end
            end
        end
    end

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: directed test-plan cases, handshake corner
// cases and randomized operands against an arithmetic reference model.
module tb_qdiv_seq;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_quotient;
    logic        o_overflow;
    logic        o_div_by_zero;

    int total = 0;
    int bad   = 0;

    qdiv_seq dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_quotient    (o_quotient),
        .o_overflow    (o_overflow),
        .o_div_by_zero (o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, div_by_zero, quotient[31:0]} from plain arithmetic.
    function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma;
        longint unsigned mb;
        longint unsigned q;
        logic            s;
        logic [30:0]     mag;
        logic            ovf;
        logic            dbz;
        ma  = 64'(a[30:0]);
        mb  = 64'(b[30:0]);
        s   = a[31] ^ b[31];
        ovf = 1'b0;
        dbz = 1'b0;
        if (mb == 0) begin
            mag = '1;
            dbz = 1'b1;
        end else begin
            q = (ma << 15) / mb;
            if (q > 64'h7FFF_FFFF) begin
                mag = '1;
                ovf = 1'b1;
            end else begin
                mag = q[30:0];
            end
        end
        if (mag == '0) s = 1'b0;
        return {ovf, dbz, s, mag};
    endfunction

    // Drive a start pulse; returns #1 after the accepting edge E0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        @(posedge i_clk);
        #1;
        i_start    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
    endtask

    // Counts edges until o_done is seen; -1 when the budget expires.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic exp_ovf, input logic exp_dbz);
        int lat;
        start_op(a, b);
        chk({tag, ".busy"}, 64'(o_busy), 64'(1));
        wait_done(lat);
        chk({tag, ".lat"}, 64'(lat), exp_dbz ? 64'(1) : 64'(46));
        chk({tag, ".q"}, 64'(o_quotient), 64'(exp_q));
        chk({tag, ".ovf"}, 64'(o_overflow), 64'(exp_ovf));
        chk({tag, ".dbz"}, 64'(o_div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        int          lat;
        int          done_seen;
        int          busy_seen;
        logic [31:0] a;
        logic [31:0] b;
        logic [33:0] r;
        logic [31:0] held_q;

        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst.busy", 64'(o_busy), 64'(0));
        chk("rst.done", 64'(o_done), 64'(0));
        chk("rst.q", 64'(o_quotient), 64'(0));
        chk("rst.ovf", 64'(o_overflow), 64'(0));
        chk("rst.dbz", 64'(o_div_by_zero), 64'(0));
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        run_div("3_over_2", 32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0);
        held_q = o_quotient;
        @(posedge i_clk);
        #1;
        chk("pulse.done", 64'(o_done), 64'(0));
        chk("pulse.busy", 64'(o_busy), 64'(0));
        repeat (3) @(posedge i_clk);
        #1;
        chk("hold.q", 64'(o_quotient), 64'(held_q));

        run_div("m1p5_over_0p5", 32'h8000_C000, 32'h0000_4000, 32'h8001_8000, 1'b0, 1'b0);
        run_div("zero_over_m1", 32'h0000_0000, 32'h8000_8000, 32'h0000_0000, 1'b0, 1'b0);
        run_div("1_over_3", 32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0);
        run_div("sat", 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_div("div0", 32'h0000_8000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_div("neg_div0", 32'h8000_8000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);

        // Start pulsed mid-RUN with other operands must be ignored.
        @(posedge i_clk);
        #1;
        start_op(32'h0001_8000, 32'h0001_0000);
        repeat (10) @(posedge i_clk);
        #1;
        i_dividend = 32'h7FFF_FFFF;
        i_divisor  = 32'h0000_0001;
        i_start    = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        wait_done(lat);
        chk("midrun.lat", 64'(lat), 64'(35));
        chk("midrun.q", 64'(o_quotient), 64'h0000_C000);
        chk("midrun.ovf", 64'(o_overflow), 64'(0));

        // Back-to-back: start issued in the DONE cycle.
        run_div("b2b", 32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0);

        // Reset held for one edge at iteration 20 aborts the division.
        start_op(32'h0001_8000, 32'h0001_0000);
        repeat (19) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        chk("abort.busy", 64'(o_busy), 64'(0));
        chk("abort.done", 64'(o_done), 64'(0));
        chk("abort.q", 64'(o_quotient), 64'(0));
        chk("abort.ovf", 64'(o_overflow), 64'(0));
        chk("abort.dbz", 64'(o_div_by_zero), 64'(0));
        done_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) done_seen++;
            if (o_busy) busy_seen++;
        end
        chk("abort.no_done", 64'(done_seen), 64'(0));
        chk("abort.no_busy", 64'(busy_seen), 64'(0));
        run_div("after_abort", 32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = {b[31], 31'($urandom_range(1, 255))};
                1: b = {b[31], 8'h00, b[22:0]};
                2: b = {b[31], 31'd0};
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) a = {a[31], 16'h0000, a[14:0]};
            r = ref_div(a, b);
            repeat ($urandom_range(0, 2)) @(posedge i_clk);
            #1;
            run_div($sformatf("rand%0d", i), a, b, r[31:0], r[33], r[32]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
